// File: rtl/scalu_rs_pkg.sv
// Shared definitions for the scalu reservation station.
//   - Sizing localparams (entry count, rob id width, operand width).
//   - A few scalu opcode encodings (the station itself never decodes them).
//   - The packed layout of one station entry.
//   - A helper that decides whether a pending operand is woken by a writeback.
package scalu_rs_pkg;

  localparam int RS_ENTRIES = 8;
  localparam int ROBID_W    = 7;
  localparam int XLEN       = 32;
  localparam int OP_W       = 5;
  localparam int RD_W       = 6;

  localparam logic [OP_W-1:0] OP_ADD = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB = 5'd1;

  // An operand is either a value (rdy=1) or a producer tag in its low ROBID_W bits (rdy=0).
  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [ROBID_W-1:0] robid;
    logic [RD_W-1:0]   rd;
    logic              op1_rdy;
    logic [XLEN-1:0]   op1;
    logic              op2_rdy;
    logic [XLEN-1:0]   op2;
  } rs_entry_t;

  // True when a still-pending operand's tag matches a live writeback.
  function automatic logic wake_hit(input logic live, input logic rdy,
                                    input logic [ROBID_W-1:0] tag,
                                    input logic [ROBID_W-1:0] wb_tag);
    return live & ~rdy & (tag == wb_tag);
  endfunction

endpackage

// File: rtl/scalu_rs_if.sv
// Bundle of the dispatch, writeback, issue and flush signals around the
// scalu reservation station.
//   master : environment side (dispatch, writeback, stall, flush drivers)
//   slave  : reservation station side
// Handshake: an issue transfers at a rising edge where exers_scalu_issue=1 and
// scalu_stall=0; while stalled the offered op stays valid and stable unless an
// older entry becomes ready. Dispatch has no ready; rs_full (registered) tells
// the dispatcher that a request this cycle will be dropped.
interface scalu_rs_if;
  import scalu_rs_pkg::*;

  logic                disp_valid;
  logic [OP_W-1:0]     disp_op;
  logic [ROBID_W-1:0]  disp_robid;
  logic [RD_W-1:0]     disp_rd;
  logic                disp_op1_rdy;
  logic [XLEN-1:0]     disp_op1;
  logic                disp_op2_rdy;
  logic [XLEN-1:0]     disp_op2;
  logic                rs_full;

  logic                wb_valid;
  logic [ROBID_W-1:0]  wb_robid;
  logic [XLEN-1:0]     wb_result;

  logic                exers_scalu_issue;
  logic [OP_W-1:0]     exers_scalu_op;
  logic [ROBID_W-1:0]  exers_robid;
  logic [RD_W-1:0]     exers_rd;
  logic [XLEN-1:0]     exers_op1;
  logic [XLEN-1:0]     exers_op2;
  logic                scalu_stall;

  logic                rob_flush;

  modport master (
    output disp_valid, disp_op, disp_robid, disp_rd,
           disp_op1_rdy, disp_op1, disp_op2_rdy, disp_op2,
           wb_valid, wb_robid, wb_result, scalu_stall, rob_flush,
    input  rs_full, exers_scalu_issue, exers_scalu_op, exers_robid,
           exers_rd, exers_op1, exers_op2
  );

  modport slave (
    input  disp_valid, disp_op, disp_robid, disp_rd,
           disp_op1_rdy, disp_op1, disp_op2_rdy, disp_op2,
           wb_valid, wb_robid, wb_result, scalu_stall, rob_flush,
    output rs_full, exers_scalu_issue, exers_scalu_op, exers_robid,
           exers_rd, exers_op1, exers_op2
  );

endinterface

// File: rtl/scalu_rs_age_matrix.sv
// Age matrix for N entries: picks the oldest requester.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : drop all age relations next cycle (flush)
//   alloc_oh  : one-hot entry being allocated this cycle (becomes youngest)
//   free_oh   : one-hot entry being released this cycle
//   req       : request vector
//   grant     : one-hot grant of the oldest requester (zero if no request)
module scalu_rs_age_matrix #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [N-1:0] alloc_oh,
  input  logic [N-1:0] free_oh,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  // older_q[r][c] = 1 : entry r is older than entry c. Diagonal stays 0.
  logic [N-1:0] older_q [N];
  logic [N-1:0] older_d [N];
  logic [N-1:0] blocked;

  always_comb begin
    for (int r = 0; r < N; r++) older_d[r] = older_q[r];
    for (int k = 0; k < N; k++) begin
      if (free_oh[k]) begin
        older_d[k] = '0;
        for (int r = 0; r < N; r++) older_d[r][k] = 1'b0;
      end
    end
    // A new entry is older than nobody and every other entry is older than it.
    for (int k = 0; k < N; k++) begin
      if (alloc_oh[k]) begin
        older_d[k] = '0;
        for (int r = 0; r < N; r++) begin
          if (r != k) older_d[r][k] = 1'b1;
        end
      end
    end
    if (clear) begin
      for (int r = 0; r < N; r++) older_d[r] = '0;
    end
  end

  // An entry is blocked when some other requester is older than it.
  always_comb begin
    blocked = '0;
    for (int c = 0; c < N; c++) begin
      for (int r = 0; r < N; r++) begin
        if (req[r] && older_q[r][c]) blocked[c] = 1'b1;
      end
    end
  end

  assign grant = req & ~blocked;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++) older_q[r] <= '0;
    end else begin
      for (int r = 0; r < N; r++) older_q[r] <= older_d[r];
    end
  end

endmodule

// File: rtl/scalu_rs.sv
// Reservation station and issue scheduler for the single-cycle scalar ALU.
// Holds dispatched ops until both operands are values, capturing them from the
// writeback broadcast, and offers the oldest ready entry to scalu each cycle.
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active-high
//   bus  : scalu_rs_if.slave (dispatch, rs_full, writeback, issue, stall, flush)
module scalu_rs
  import scalu_rs_pkg::*;
(
  input logic       clk,
  input logic       rst,
  scalu_rs_if.slave bus
);

  rs_entry_t ent_q [RS_ENTRIES];
  rs_entry_t ent_d [RS_ENTRIES];
  logic      full_q, full_d;

  logic [RS_ENTRIES-1:0] ready_vec, grant, alloc_oh, free_oh;
  logic                  disp_fire, issue_w, issue_fire;
  rs_entry_t             new_ent;

  logic [OP_W-1:0]    mux_op;
  logic [ROBID_W-1:0] mux_robid;
  logic [RD_W-1:0]    mux_rd;
  logic [XLEN-1:0]    mux_op1, mux_op2;

  // Readiness comes from registered state only, so a wakeup issues a cycle later.
  always_comb begin
    for (int i = 0; i < RS_ENTRIES; i++)
      ready_vec[i] = ent_q[i].valid & ent_q[i].op1_rdy & ent_q[i].op2_rdy;
  end

  assign disp_fire  = bus.disp_valid & ~full_q & ~bus.rob_flush;
  assign issue_w    = (|ready_vec) & ~bus.rob_flush;
  assign issue_fire = issue_w & ~bus.scalu_stall;
  assign free_oh    = grant & {RS_ENTRIES{issue_fire}};

  // Lowest-index free slot; entries freed this cycle are not yet counted free.
  always_comb begin
    alloc_oh = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (!ent_q[i].valid) begin
        alloc_oh    = '0;
        alloc_oh[i] = 1'b1;
      end
    end
    if (!disp_fire) alloc_oh = '0;
  end

  scalu_rs_age_matrix #(.N(RS_ENTRIES)) u_age (
    .clk      (clk),
    .rst      (rst),
    .clear    (bus.rob_flush),
    .alloc_oh (alloc_oh),
    .free_oh  (free_oh),
    .req      (ready_vec),
    .grant    (grant)
  );

  // Incoming entry, with same-cycle writeback bypass on each pending operand.
  always_comb begin
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.op      = bus.disp_op;
    new_ent.robid   = bus.disp_robid;
    new_ent.rd      = bus.disp_rd;
    new_ent.op1_rdy = bus.disp_op1_rdy;
    new_ent.op1     = bus.disp_op1;
    new_ent.op2_rdy = bus.disp_op2_rdy;
    new_ent.op2     = bus.disp_op2;
    if (wake_hit(bus.wb_valid, bus.disp_op1_rdy, bus.disp_op1[ROBID_W-1:0], bus.wb_robid)) begin
      new_ent.op1_rdy = 1'b1;
      new_ent.op1     = bus.wb_result;
    end
    if (wake_hit(bus.wb_valid, bus.disp_op2_rdy, bus.disp_op2[ROBID_W-1:0], bus.wb_robid)) begin
      new_ent.op2_rdy = 1'b1;
      new_ent.op2     = bus.wb_result;
    end
  end

  // Wakeup, issue-free and allocation act independently; flush overrides all.
  always_comb begin
    full_d = 1'b1;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      ent_d[i] = ent_q[i];
      if (wake_hit(ent_q[i].valid & bus.wb_valid, ent_q[i].op1_rdy,
                   ent_q[i].op1[ROBID_W-1:0], bus.wb_robid)) begin
        ent_d[i].op1_rdy = 1'b1;
        ent_d[i].op1     = bus.wb_result;
      end
      if (wake_hit(ent_q[i].valid & bus.wb_valid, ent_q[i].op2_rdy,
                   ent_q[i].op2[ROBID_W-1:0], bus.wb_robid)) begin
        ent_d[i].op2_rdy = 1'b1;
        ent_d[i].op2     = bus.wb_result;
      end
      if (free_oh[i])     ent_d[i].valid = 1'b0;
      if (alloc_oh[i])    ent_d[i]       = new_ent;
      if (bus.rob_flush)  ent_d[i].valid = 1'b0;
      full_d = full_d & ent_d[i].valid;
    end
  end

  // One-hot grant, so an OR-mux selects the issuing entry.
  always_comb begin
    mux_op    = '0;
    mux_robid = '0;
    mux_rd    = '0;
    mux_op1   = '0;
    mux_op2   = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (grant[i]) begin
        mux_op    = mux_op    | ent_q[i].op;
        mux_robid = mux_robid | ent_q[i].robid;
        mux_rd    = mux_rd    | ent_q[i].rd;
        mux_op1   = mux_op1   | ent_q[i].op1;
        mux_op2   = mux_op2   | ent_q[i].op2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_ENTRIES; i++) ent_q[i] <= '0;
      full_q <= 1'b0;
    end else begin
      for (int i = 0; i < RS_ENTRIES; i++) ent_q[i] <= ent_d[i];
      full_q <= full_d;
    end
  end

  assign bus.rs_full           = full_q;
  assign bus.exers_scalu_issue = issue_w;
  assign bus.exers_scalu_op    = mux_op;
  assign bus.exers_robid       = mux_robid;
  assign bus.exers_rd          = mux_rd;
  assign bus.exers_op1         = mux_op1;
  assign bus.exers_op2         = mux_op2;

endmodule
